uart_rx_fifo: RTL and testbench

Receive-side byte buffer sitting directly downstream of the UART receiver. It captures each received word on the rising edge of the receiver's data-valid output and stores it in a circular FIFO. The FIFO presents the stored words to the host/consumer over a first-word-fall-through valid/ready read port. It tracks occupancy and flags overrun, counting the words it drops.

---
 rtl/uart_rx_fifo_if.sv | 34 +++
 rtl/uart_rx_fifo.sv | 105 ++++++++++
 tb/tb_uart_rx_fifo.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver/consumer side and the receive FIFO.
interface uart_rx_fifo_if #(
  parameter int unsigned N_DATA_BITS = 8,
  parameter int unsigned DEPTH       = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [N_DATA_BITS-1:0] i_data;
  logic                   i_data_valid;
  logic                   i_rd_ready;
  logic                   i_clr_overrun;
  logic [N_DATA_BITS-1:0] o_rd_data;
  logic                   o_rd_valid;
  logic [CW-1:0]          o_count;
  logic                   o_empty;
  logic                   o_full;
  logic                   o_almost_full;
  logic                   o_overrun;
  logic [7:0]             o_drop_count;

  // FIFO side
  modport slave (
    input  i_data, i_data_valid, i_rd_ready, i_clr_overrun,
    output o_rd_data, o_rd_valid, o_count, o_empty, o_full,
           o_almost_full, o_overrun, o_drop_count
  );

  // Receiver / consumer side
  modport master (
    output i_data, i_data_valid, i_rd_ready, i_clr_overrun,
    input  o_rd_data, o_rd_valid, o_count, o_empty, o_full,
           o_almost_full, o_overrun, o_drop_count
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: edge-triggered capture, first-word-fall-through
// read port, registered occupancy flags and sticky overrun with saturating drop count.
module uart_rx_fifo #(
  parameter int unsigned N_DATA_BITS       = 8,
  parameter int unsigned DEPTH             = 16,
  parameter int unsigned ALMOST_FULL_LEVEL = 12
) (
  input  logic          i_clk,
  input  logic          i_reset,
  uart_rx_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned DW = 8;

  logic [N_DATA_BITS-1:0] mem [DEPTH];

  logic [PW-1:0]          wr_ptr, rd_ptr, count_q;
  logic                   valid_q, empty_q, full_q, afull_q, overrun_q;
  logic [DW-1:0]          drop_q;
  logic [N_DATA_BITS-1:0] rd_data_q;

  logic [PW-1:0]          wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic                   wr_stb, pop, push, drop;
  logic                   empty_nxt, full_nxt, afull_nxt, overrun_nxt;
  logic [DW-1:0]          drop_nxt;
  logic [N_DATA_BITS-1:0] rd_data_nxt;

  // Next-state for pointers, flags, head word and overrun tracking
  always_comb begin
    wr_stb      = bus.i_data_valid & ~valid_q;
    pop         = ~empty_q & bus.i_rd_ready;
    push        = wr_stb & (~full_q | pop);
    drop        = wr_stb & full_q & ~pop;

    wr_ptr_nxt  = wr_ptr + PW'(push);
    rd_ptr_nxt  = rd_ptr + PW'(pop);
    count_nxt   = wr_ptr_nxt - rd_ptr_nxt;
    empty_nxt   = (wr_ptr_nxt == rd_ptr_nxt);
    full_nxt    = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                  (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
    afull_nxt   = (count_nxt >= PW'(ALMOST_FULL_LEVEL));

    // Head register must see a word landing in the slot it is about to expose
    if (push && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0]))
      rd_data_nxt = bus.i_data;
    else
      rd_data_nxt = mem[rd_ptr_nxt[AW-1:0]];

    overrun_nxt = overrun_q;
    drop_nxt    = drop_q;
    if (drop) begin
      overrun_nxt = 1'b1;
      if (bus.i_clr_overrun)
        drop_nxt = DW'(1);
      else if (drop_q != {DW{1'b1}})
        drop_nxt = drop_q + DW'(1);
    end else if (bus.i_clr_overrun) begin
      overrun_nxt = 1'b0;
      drop_nxt    = '0;
    end
  end

  // Control and status registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      valid_q   <= 1'b1;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      overrun_q <= 1'b0;
      drop_q    <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count_q   <= count_nxt;
      valid_q   <= bus.i_data_valid;
      empty_q   <= empty_nxt;
      full_q    <= full_nxt;
      afull_q   <= afull_nxt;
      overrun_q <= overrun_nxt;
      drop_q    <= drop_nxt;
      rd_data_q <= rd_data_nxt;
    end
  end

  // Storage array; contents are meaningless once pointers are reset
  always_ff @(posedge i_clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= bus.i_data;
  end

  assign bus.o_rd_data     = rd_data_q;
  assign bus.o_rd_valid    = ~empty_q;
  assign bus.o_count       = count_q;
  assign bus.o_empty       = empty_q;
  assign bus.o_full        = full_q;
  assign bus.o_almost_full = afull_q;
  assign bus.o_overrun     = overrun_q;
  assign bus.o_drop_count  = drop_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: ordering, edge capture, flags, overrun and a
// randomized push/pop run checked against a reference queue.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  uart_rx_fifo_if #(.N_DATA_BITS(8), .DEPTH(16)) bus ();

  uart_rx_fifo #(.N_DATA_BITS(8), .DEPTH(16), .ALMOST_FULL_LEVEL(12)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    bus.i_data       = d;
    bus.i_data_valid = 1'b1;
    tick();
    bus.i_data_valid = 1'b0;
    tick();
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_b;
  logic       prev_v, v, r, stb, pp;
  int         writes, reads;

  initial begin
    rst = 1'b1;
    bus.i_data = '0; bus.i_data_valid = 1'b0;
    bus.i_rd_ready = 1'b0; bus.i_clr_overrun = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_count", 32'(bus.o_count), 0);
    chk("rst_empty", 32'(bus.o_empty), 1);
    chk("rst_full", 32'(bus.o_full), 0);
    chk("rst_afull", 32'(bus.o_almost_full), 0);
    chk("rst_valid", 32'(bus.o_rd_valid), 0);
    chk("rst_ovr", 32'(bus.o_overrun), 0);
    chk("rst_drop", 32'(bus.o_drop_count), 0);
    chk("rst_data", 32'(bus.o_rd_data), 0);

    // Three words, then drain in order
    push(8'hA5); push(8'h3C); push(8'h7E);
    chk("t1_count", 32'(bus.o_count), 3);
    chk("t1_head", 32'(bus.o_rd_data), 32'hA5);
    chk("t1_valid", 32'(bus.o_rd_valid), 1);
    bus.i_rd_ready = 1'b1;
    chk("t1_rd0", 32'(bus.o_rd_data), 32'hA5); tick();
    chk("t1_rd1", 32'(bus.o_rd_data), 32'h3C); tick();
    chk("t1_rd2", 32'(bus.o_rd_data), 32'h7E); tick();
    bus.i_rd_ready = 1'b0;
    chk("t1_empty", 32'(bus.o_empty), 1);
    chk("t1_cnt0", 32'(bus.o_count), 0);

    // Held valid writes once; held valid across reset release writes nothing
    bus.i_data = 8'h55; bus.i_data_valid = 1'b1;
    repeat (5) tick();
    chk("t2_count", 32'(bus.o_count), 1);
    chk("t2_head", 32'(bus.o_rd_data), 32'h55);
    rst = 1'b1; #1;
    chk("t2_async", 32'(bus.o_count), 0);
    tick(); tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("t2_nowr", 32'(bus.o_count), 0);
    chk("t2_empty", 32'(bus.o_empty), 1);
    bus.i_data_valid = 1'b0;
    tick();

    // Fill to full, watch almost-full threshold, then overrun
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      chk("t3_count", 32'(bus.o_count), 32'(i + 1));
      chk("t3_afull", 32'(bus.o_almost_full), 32'((i + 1) >= 12));
    end
    chk("t3_full", 32'(bus.o_full), 1);
    push(8'hFF);
    chk("t3_ovr", 32'(bus.o_overrun), 1);
    chk("t3_drop", 32'(bus.o_drop_count), 1);
    chk("t3_head", 32'(bus.o_rd_data), 0);
    chk("t3_cnt16", 32'(bus.o_count), 16);

    // Push and pop together while full: no drop
    bus.i_data = 8'hEE; bus.i_data_valid = 1'b1; bus.i_rd_ready = 1'b1;
    tick();
    bus.i_data_valid = 1'b0; bus.i_rd_ready = 1'b0;
    chk("t4_count", 32'(bus.o_count), 16);
    chk("t4_drop", 32'(bus.o_drop_count), 1);
    chk("t4_head", 32'(bus.o_rd_data), 1);
    tick();
    bus.i_rd_ready = 1'b1;
    for (int i = 1; i < 17; i++) begin
      exp_b = (i == 16) ? 8'hEE : 8'(i);
      chk("t4_rd", 32'(bus.o_rd_data), 32'(exp_b));
      tick();
    end
    bus.i_rd_ready = 1'b0;
    chk("t4_empty", 32'(bus.o_empty), 1);

    // Drop-count saturation and clear priority
    for (int i = 0; i < 16; i++) push(8'(i));
    for (int i = 0; i < 300; i++) push(8'hC3);
    chk("t5_sat", 32'(bus.o_drop_count), 255);
    chk("t5_ovr", 32'(bus.o_overrun), 1);
    bus.i_data_valid = 1'b1; bus.i_clr_overrun = 1'b1;
    tick();
    bus.i_data_valid = 1'b0; bus.i_clr_overrun = 1'b0;
    chk("t5_clrdrop_ovr", 32'(bus.o_overrun), 1);
    chk("t5_clrdrop_cnt", 32'(bus.o_drop_count), 1);
    tick();
    bus.i_clr_overrun = 1'b1;
    tick();
    bus.i_clr_overrun = 1'b0;
    chk("t5_clr_ovr", 32'(bus.o_overrun), 0);
    chk("t5_clr_cnt", 32'(bus.o_drop_count), 0);
    chk("t5_cnt16", 32'(bus.o_count), 16);
    bus.i_rd_ready = 1'b1;
    repeat (16) tick();
    bus.i_rd_ready = 1'b0;
    chk("t5_empty", 32'(bus.o_empty), 1);

    // Random push/pop traffic against a reference queue; long enough to wrap twice
    prev_v = 1'b0; writes = 0; reads = 0;
    for (int c = 0; c < 200; c++) begin
      v  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      bus.i_data       = 8'($urandom_range(0, 255));
      bus.i_data_valid = v;
      bus.i_rd_ready   = r;
      stb = v & ~prev_v;
      pp  = (q.size() > 0) && r;
      chk("t6_valid", 32'(bus.o_rd_valid), 32'(q.size() > 0));
      if (pp) begin
        chk("t6_rd", 32'(bus.o_rd_data), 32'(q[0]));
      end
      tick();
      if (stb && (q.size() < 16 || pp)) begin
        q.push_back(bus.i_data);
        writes++;
      end
      if (pp) begin
        void'(q.pop_front());
        reads++;
      end
      prev_v = v;
      chk("t6_count", 32'(bus.o_count), 32'(writes - reads));
    end
    bus.i_data_valid = 1'b0; bus.i_rd_ready = 1'b0;
    tick();
    if (writes < 33) begin
      $display("FAIL t6_wrap observed=%0d expected>=33", writes);
      bad++;
    end
    total++;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
